// File: rtl/fu_dispatch.sv
// fu_dispatch: issues one decode ALU request at a time to the external FU
// (aluop/op1/op2 writes, CSR handshake, op3 read) and guards it with a watchdog.
module fu_dispatch #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_aluop,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [4:0]  req_rd,
    output logic [35:0] from_DE_to_FU,
    input  logic [34:0] from_FU_to_DE,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        fu_err
);

    // state       | meaning
    // IDLE        | ready for a decode request (unless fu_err)
    // ISSUE_ALUOP | one-cycle aluop write
    // ISSUE_OP1   | one-cycle op1 write
    // WAIT_OP2    | op2 write held until csr_out[0]
    // WAIT_DONE   | no strobes, waiting for csr_out[2]
    // READ        | one-cycle op3 read, result captured
    // RESPOND     | result held until decode takes it
    // HALT        | FU hung earlier; dead until reset

    localparam int ALUOPBITS = 4;
    localparam int DBITS     = 32;
    localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, ISSUE_ALUOP, ISSUE_OP1, WAIT_OP2, WAIT_DONE, READ, RESPOND, HALT
    } state_t;

    state_t           state;
    logic [DBITS-1:0] op1_q;
    logic [DBITS-1:0] op2_q;
    logic [9:0]       wd_cnt;
    logic             wr_aluop;
    logic             wr_op1;
    logic             wr_op2;
    logic             rd_op3;
    logic [DBITS-1:0] wr_data;

    logic             csr_op2_taken;
    logic             csr_done;
    logic [DBITS-1:0] op3;
    logic             unused_csr1;

    assign csr_op2_taken = from_FU_to_DE[32];
    assign csr_done      = from_FU_to_DE[34];
    assign unused_csr1   = from_FU_to_DE[33];
    assign op3           = from_FU_to_DE[31:0];

    assign from_DE_to_FU = {rd_op3, wr_data, wr_op2, wr_op1, wr_aluop};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op1_q     <= '0;
            op2_q     <= '0;
            wd_cnt    <= '0;
            wr_aluop  <= 1'b0;
            wr_op1    <= 1'b0;
            wr_op2    <= 1'b0;
            rd_op3    <= 1'b0;
            wr_data   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
            fu_err    <= 1'b0;
        end else begin
            wr_aluop <= 1'b0;
            wr_op1   <= 1'b0;
            wr_op2   <= 1'b0;
            rd_op3   <= 1'b0;
            wr_data  <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op1_q     <= req_op1;
                        op2_q     <= req_op2;
                        rsp_rd    <= req_rd;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b0;
                        wr_aluop  <= 1'b1;
                        wr_data   <= {{(DBITS-ALUOPBITS){1'b0}}, req_aluop};
                        state     <= ISSUE_ALUOP;
                    end
                end
                ISSUE_ALUOP: begin
                    wr_op1  <= 1'b1;
                    wr_data <= op1_q;
                    state   <= ISSUE_OP1;
                end
                ISSUE_OP1: begin
                    wr_op2  <= 1'b1;
                    wr_data <= op2_q;
                    wd_cnt  <= '0;
                    state   <= WAIT_OP2;
                end
                WAIT_OP2: begin
                    if (wd_cnt == TO_LIM) begin
                        fu_err    <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else if (csr_op2_taken) begin
                        wd_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else begin
                        wr_op2  <= 1'b1;
                        wr_data <= op2_q;
                        wd_cnt  <= wd_cnt + 10'd1;
                    end
                end
                WAIT_DONE: begin
                    // csr_out[2] is only honoured here, never in WAIT_OP2
                    if (wd_cnt == TO_LIM) begin
                        fu_err    <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RESPOND;
                    end else if (csr_done) begin
                        rd_op3 <= 1'b1;
                        state  <= READ;
                    end else begin
                        wd_cnt <= wd_cnt + 10'd1;
                    end
                end
                READ: begin
                    rsp_data  <= op3;
                    rsp_valid <= 1'b1;
                    state     <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (fu_err) begin
                            state <= HALT;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fu_dispatch.sv
// Bench for fu_dispatch: table of directed requests against a small FU model,
// plus hand sequences for reset in WAIT_DONE and the watchdog/HALT path.
module tb_fu_dispatch;

    typedef struct {
        logic [3:0]  aluop;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        int          d0;
        int          d1;
        bit          early;
        int          bp;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_aluop;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [4:0]  req_rd;
    logic [35:0] from_DE_to_FU;
    logic [34:0] from_FU_to_DE;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        fu_err;

    int total = 0;
    int bad = 0;
    int aluop_viol = 0;
    int onehot_viol = 0;
    int data_viol = 0;

    fu_dispatch #(.TIMEOUT_CYCLES(15)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_aluop     (req_aluop),
        .req_op1       (req_op1),
        .req_op2       (req_op2),
        .req_rd        (req_rd),
        .from_DE_to_FU (from_DE_to_FU),
        .from_FU_to_DE (from_FU_to_DE),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_rd        (rsp_rd),
        .rsp_err       (rsp_err),
        .fu_err        (fu_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        wr_aluop, wr_op1, wr_op2, rd_op3;
    logic [31:0] wr_data;
    assign wr_aluop = from_DE_to_FU[0];
    assign wr_op1   = from_DE_to_FU[1];
    assign wr_op2   = from_DE_to_FU[2];
    assign wr_data  = from_DE_to_FU[34:3];
    assign rd_op3   = from_DE_to_FU[35];

    // FU model: csr0 after d0 extra op2 cycles, done d1 cycles into compute
    int          fu_d0, fu_d1;
    bit          fu_early;
    int          fu_cnt0, fu_cnt1;
    bit          fu_busy, fu_comp;
    logic [3:0]  fu_aluop;
    logic [31:0] fu_op1, fu_op2, fu_res;
    logic        csr0, csr2;

    always_comb begin
        case (fu_aluop)
            4'd0:    fu_res = fu_op1 + fu_op2;
            4'd1:    fu_res = fu_op1 - fu_op2;
            4'd2:    fu_res = fu_op1 & fu_op2;
            4'd3:    fu_res = fu_op1 | fu_op2;
            4'd4:    fu_res = fu_op1 ^ fu_op2;
            default: fu_res = 32'h0;
        endcase
    end

    assign csr0 = wr_op2 && (fu_cnt0 >= fu_d0);
    assign csr2 = fu_early || (fu_comp && (fu_cnt1 >= fu_d1));
    assign from_FU_to_DE = {csr2, 1'b0, csr0, fu_res};

    always @(posedge clk) begin
        if (reset) begin
            fu_busy  <= 1'b0;
            fu_comp  <= 1'b0;
            fu_cnt0  <= 0;
            fu_cnt1  <= 0;
            fu_aluop <= 4'h0;
            fu_op1   <= 32'h0;
            fu_op2   <= 32'h0;
        end else begin
            if (wr_aluop) begin
                if (fu_busy) aluop_viol <= aluop_viol + 1;
                fu_busy  <= 1'b1;
                fu_aluop <= wr_data[3:0];
                fu_cnt0  <= 0;
                fu_comp  <= 1'b0;
            end
            if (wr_op1) fu_op1 <= wr_data;
            if (fu_comp) fu_cnt1 <= fu_cnt1 + 1;
            if (wr_op2) begin
                fu_op2  <= wr_data;
                fu_cnt0 <= fu_cnt0 + 1;
                if (csr0) begin
                    fu_comp <= 1'b1;
                    fu_cnt1 <= 0;
                end
            end
            if (rd_op3) begin
                fu_busy <= 1'b0;
                fu_comp <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if ($countones({rd_op3, wr_op2, wr_op1, wr_aluop}) > 1) onehot_viol <= onehot_viol + 1;
            if (!(rd_op3 || wr_op2 || wr_op1 || wr_aluop) && wr_data != 32'h0) data_viol <= data_viol + 1;
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk(name, {from_DE_to_FU, req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err, fu_err},
            {36'h0, 1'b1, 1'b0, 32'h0, 5'h0, 1'b0, 1'b0});
    endtask

    task automatic do_req(input vec_t v, input int idx);
        int  lat, f_al, f_o1, f_o2, f_rd, n_o2, n_rd, guard;
        bit  op2_ok;
        fu_d0 = v.d0;
        fu_d1 = v.d1;
        fu_early = v.early;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_ready", idx), {95'h0, req_ready}, 96'h1);
        req_valid = 1'b1;
        req_aluop = v.aluop;
        req_op1   = v.op1;
        req_op2   = v.op2;
        req_rd    = v.rd;
        rsp_ready = (v.bp == 0);
        lat = 0; f_al = 0; f_o1 = 0; f_o2 = 0; f_rd = 0; n_o2 = 0; n_rd = 0; op2_ok = 1'b1;
        for (int k = 1; k <= 200 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (wr_aluop && f_al == 0) f_al = k;
            if (wr_op1 && f_o1 == 0) f_o1 = k;
            if (wr_op2 && f_o2 == 0) f_o2 = k;
            if (rd_op3 && f_rd == 0) f_rd = k;
            if (wr_op2) begin
                n_o2++;
                if (wr_data !== v.op2) op2_ok = 1'b0;
            end
            if (rd_op3) n_rd++;
            if (rsp_valid) lat = k;
        end
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_strobe_order", idx), {8'(f_al), 8'(f_o1), 8'(f_o2), 8'(f_rd)},
            {8'd1, 8'd2, 8'd3, 8'(v.exp_lat - 1)});
        chk($sformatf("v%0d_op2_cycles", idx), n_o2, v.d0 + 1);
        chk($sformatf("v%0d_op2_data_held", idx), {95'h0, op2_ok}, 96'h1);
        chk($sformatf("v%0d_read_pulses", idx), n_rd, 1);
        chk($sformatf("v%0d_rsp", idx), {rsp_data, rsp_rd, rsp_err, req_ready},
            {v.exp_data, v.rd, 1'b0, 1'b0});
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_bp_hold", idx),
                {rsp_valid, rsp_data, rsp_rd, rsp_err, req_ready, from_DE_to_FU},
                {1'b1, v.exp_data, v.rd, 1'b0, 1'b0, 36'h0});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_after_hs", idx), {rsp_valid, req_ready}, {1'b0, 1'b1});
    endtask

    vec_t vecs[11];
    int   to_lat, to_nrd;

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_aluop = 4'h0; req_op1 = 32'h0; req_op2 = 32'h0;
        req_rd = 5'h0; rsp_ready = 1'b0; fu_d0 = 0; fu_d1 = 0; fu_early = 1'b0;

        vecs[0]  = '{4'd0, 32'd5,        32'd7,        5'd3,  0, 0,  1'b0, 0, 32'd12,       6};
        vecs[1]  = '{4'd1, 32'd100,      32'd30,       5'd9,  4, 10, 1'b0, 5, 32'd70,       20};
        vecs[2]  = '{4'd0, 32'hFFFFFFFF, 32'd1,        5'd31, 0, 0,  1'b1, 0, 32'h0,        6};
        vecs[3]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd1,  1, 0,  1'b0, 0, 32'h00F000F0, 7};
        vecs[4]  = '{4'd3, 32'h12340000, 32'h00005678, 5'd2,  0, 2,  1'b0, 0, 32'h12345678, 8};
        vecs[5]  = '{4'd4, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd4,  2, 1,  1'b0, 0, 32'h55555555, 9};
        vecs[6]  = '{4'd0, 32'h7FFFFFFF, 32'd1,        5'd5,  0, 0,  1'b0, 0, 32'h80000000, 6};
        vecs[7]  = '{4'd1, 32'd3,        32'd5,        5'd6,  3, 3,  1'b0, 0, 32'hFFFFFFFE, 12};
        vecs[8]  = '{4'd0, 32'd1000,     32'd2345,     5'd7,  0, 5,  1'b0, 0, 32'd3345,     11};
        vecs[9]  = '{4'd4, 32'h0000FFFF, 32'h00FF00FF, 5'd30, 1, 1,  1'b0, 0, 32'h00FFFF00, 8};
        vecs[10] = '{4'd2, 32'hDEADBEEF, 32'hFFFF0000, 5'd16, 5, 0,  1'b0, 0, 32'hDEAD0000, 11};

        repeat (2) @(negedge clk);
        chk_reset("reset_state");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {req_ready, rsp_valid, from_DE_to_FU}, {1'b1, 1'b0, 36'h0});

        for (int i = 0; i < 11; i++) do_req(vecs[i], i);

        // reset while the FU is computing
        fu_d0 = 0; fu_d1 = 10; fu_early = 1'b0;
        req_valid = 1'b1; req_aluop = 4'd3; req_op1 = 32'h11; req_op2 = 32'h22; req_rd = 5'd21;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_wait_done", {from_DE_to_FU, rsp_valid, req_ready, rsp_rd}, {36'h0, 1'b0, 1'b0, 5'd21});
        reset = 1'b1;
        @(negedge clk);
        chk_reset("mid_reset_values");
        reset = 1'b0;
        do_req(vecs[5], 11);

        // FU never finishes: watchdog, sticky error, HALT
        fu_d0 = 0; fu_d1 = 100000; fu_early = 1'b0;
        req_valid = 1'b1; req_aluop = 4'd0; req_op1 = 32'd11; req_op2 = 32'd22; req_rd = 5'd12;
        rsp_ready = 1'b0;
        to_lat = 0; to_nrd = 0;
        for (int k = 1; k <= 100 && to_lat == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (rd_op3) to_nrd++;
            if (rsp_valid) to_lat = k;
        end
        chk("to_latency", to_lat, 20);
        chk("to_no_read", to_nrd, 0);
        chk("to_rsp", {rsp_err, rsp_data, rsp_rd, fu_err, req_ready, from_DE_to_FU},
            {1'b1, 32'h0, 5'd12, 1'b1, 1'b0, 36'h0});
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("to_after_hs", {rsp_valid, req_ready, fu_err}, {1'b0, 1'b0, 1'b1});
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("halt_hold", {req_ready, fu_err, rsp_valid, from_DE_to_FU}, {1'b0, 1'b1, 1'b0, 36'h0});
        end
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset("halt_reset");
        reset = 1'b0;
        do_req(vecs[4], 12);

        chk("aluop_while_fu_busy", aluop_viol, 0);
        chk("strobe_onehot", onehot_viol, 0);
        chk("wr_data_idle_zero", data_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
